// File: rtl/l1_mem_arbiter_pkg.sv
// Shared definitions for the L1 memory-bus arbiter.
//   arb_state_t : arbiter FSM encodings (IDLE / granted to L1I / granted to L1D)
//   WORD_OFF    : log2 of the beat stride in bytes (4-byte beats)
package l1_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10
  } arb_state_t;

  localparam int unsigned WORD_OFF = 2;

endpackage

// File: rtl/l1_mem_arbiter_rr_arb2.sv
// Two-requester round-robin pick with a registered last-winner bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : L1I request
//   d_req      : L1D request
//   take       : the current pick is accepted this cycle; remember the winner
//   win_i      : L1I is picked
//   win_d      : L1D is picked
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic take,
  output logic win_i,
  output logic win_d
);

  // 1 = L1D won last; reset to D so L1I wins the first tie.
  logic last_d;

  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    if (i_req && d_req) begin
      win_i = last_d;
      win_d = !last_d;
    end else begin
      win_i = i_req;
      win_d = d_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b1;
    end else if (take && (win_i || win_d)) begin
      last_d <= win_d;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares the refill/writeback memory bus between L1I (refills) and L1D
// (refills and writebacks). Each grant runs a BEATS-word burst with a
// per-beat address counter; one idle cycle separates bursts.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_req/i_addr                    : L1I refill request and miss address
//   i_grant/i_rvalid/i_rdata/i_done : L1I ownership, read beats, last-beat pulse
//   d_req/d_we/d_addr/d_wdata       : L1D request, direction, address, write beat
//   d_grant/d_wready/d_rvalid/
//   d_rdata/d_done                  : L1D ownership, write accept, read beats, last-beat pulse
//   m_req/m_we/m_addr/m_wdata       : memory-side beat request
//   m_ack/m_rdata                   : memory-side beat completion and read data
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_wready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF_W = CNT_W + WORD_OFF;
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] line_addr;
  logic              lat_we;
  logic              win_i, win_d;
  logic              idle;
  logic              beat_ack;
  logic              last_ack;

  assign idle = (state_q == ARB_IDLE);

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (i_req),
    .d_req (d_req),
    .take  (idle),
    .win_i (win_i),
    .win_d (win_d)
  );

  // m_ack only counts while a beat is actually requested.
  assign beat_ack = !idle && m_ack;
  assign last_ack = beat_ack && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_i) begin
          state_d = ARB_GNT_I;
        end else if (win_d) begin
          state_d = ARB_GNT_D;
        end
      end
      ARB_GNT_I, ARB_GNT_D: begin
        if (last_ack) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      line_addr <= '0;
      lat_we    <= 1'b0;
    end else if (idle) begin
      if (win_i) begin
        line_addr <= i_addr & LINE_MASK;
        lat_we    <= 1'b0;
        beat_cnt  <= '0;
      end else if (win_d) begin
        line_addr <= d_addr & LINE_MASK;
        lat_we    <= d_we;
        beat_cnt  <= '0;
      end
    end else if (beat_ack) begin
      beat_cnt <= last_ack ? '0 : beat_cnt + 1'b1;
    end
  end

  always_comb begin
    i_grant  = (state_q == ARB_GNT_I);
    d_grant  = (state_q == ARB_GNT_D);
    m_req    = !idle;
    m_we     = !idle && lat_we;
    m_addr   = idle ? '0 : (line_addr | (ADDR_W'(beat_cnt) << WORD_OFF));
    m_wdata  = d_grant ? d_wdata : '0;
    i_rvalid = i_grant && m_ack;
    i_rdata  = i_grant ? m_rdata : '0;
    i_done   = i_grant && last_ack;
    d_rvalid = d_grant && !lat_we && m_ack;
    d_wready = d_grant && lat_we && m_ack;
    d_rdata  = d_grant ? m_rdata : '0;
    d_done   = d_grant && last_ack;
  end

endmodule
